calc_sequencer: RTL
===================

Name: calc_sequencer

Overview:
- Top-level control FSM for the switch-driven calculator.
- Collects operand A, an operator and operand B from the switches, one confirm press per item.
- Starts the shared ALU with a start/done handshake and holds the result for display.
- Adds debounced-edge handling, a bounded ALU wait and error reporting.

Parameters:
WIDTH, 4, operand width in bits
RES_W, 8, result width in bits
TIMEOUT, 64, max cycles waiting for alu_done before error

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low reset
sw  input  WIDTH  operand value from switches
op_sw  input  2  operator select: 00 add, 01 sub, 10 mul, 11 div
confirm  input  1  level confirm button, already debounced
cancel  input  1  level abort button, already debounced
alu_a  output  WIDTH  operand A to ALU
alu_b  output  WIDTH  operand B to ALU
alu_op  output  2  latched operator to ALU
alu_start  output  1  one-cycle start pulse
alu_done  input  1  ALU completion strobe
alu_result  input  RES_W  ALU result, valid with alu_done
alu_err  input  1  ALU error (e.g. div by zero), valid with alu_done
result  output  RES_W  held result for display
result_valid  output  1  result register holds a fresh result
error  output  1  last operation failed (ALU error or timeout)
state_dbg  output  3  current state encoding for LEDs

Behaviour:
- Reset (reset==0 at posedge clk) forces:
  - state IDLE_A, all data outputs 0, alu_start 0, result_valid 0, error 0, timeout counter 0.
  - Edge-detect registers are loaded with the current confirm/cancel values, so a button held through reset does not fire.
- Edge detection: conf_evt = confirm & ~confirm_q; cancel_evt likewise. Exactly one event per press regardless of hold length.
- State encoding (state_dbg): IDLE_A=0, GET_OP=1, GET_B=2, START=3, WAIT=4, SHOW=5.
- IDLE_A:
  - On conf_evt: alu_a<=sw; clear result_valid and error; go to GET_OP.
- GET_OP:
  - On conf_evt: alu_op<=op_sw; go to GET_B.
- GET_B:
  - On conf_evt: alu_b<=sw; go to START.
- START:
  - Single cycle with alu_start=1, counter cleared; always go to WAIT next cycle.
  - alu_start is high only in START, so latency from the B confirm edge to alu_start is 1 cycle.
- WAIT:
  - Counter increments each cycle.
  - On alu_done: result<=alu_result; error<=alu_err; result_valid<=~alu_err; go to SHOW.
  - If the counter reaches TIMEOUT-1 without alu_done: error<=1, result_valid<=0, result unchanged; go to SHOW.
  - alu_done and timeout in the same cycle: alu_done wins.
  - conf_evt is ignored.
- SHOW:
  - Outputs held.
  - On conf_evt: alu_a<=sw, clear result_valid and error, go to GET_OP (chained new calculation).
- cancel_evt in IDLE_A, GET_OP or GET_B:
  - Return to IDLE_A; alu_a, alu_b and alu_op cleared; result and flags unchanged.
- cancel_evt in START or WAIT:
  - Ignored; an issued operation always completes or times out.
- cancel_evt in SHOW:
  - Go to IDLE_A; clear result, result_valid and error.
- conf_evt and cancel_evt in the same cycle: cancel takes priority where cancel is honoured; otherwise confirm is processed.
- alu_done outside WAIT is ignored.
- No arithmetic inside the block; result is taken verbatim, width RES_W.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset held low 3 cycles with confirm high, then released -> state_dbg=0, all outputs 0, no conf_evt until confirm falls and rises again.
- Normal flow: sw=5 confirm, op_sw=00 confirm, sw=3 confirm; model ALU returns 8 with alu_done 4 cycles after start -> alu_start 1-cycle pulse exactly 1 cycle after the third edge; alu_a=5, alu_b=3, alu_op=0; result=8, result_valid=1, state_dbg=5.
- Division by zero: A=9, op=11, B=0; ALU returns alu_err=1 -> error=1, result_valid=0, state SHOW; cancel -> IDLE_A, result=0, error=0.
- Timeout with no alu_done: -> after TIMEOUT cycles in WAIT, error=1 and SHOW; alu_done arriving afterwards is ignored.
- Cancel in GET_B after A=7, op=10 -> IDLE_A with alu_a=0 and alu_op=0; cancel pulsed during WAIT -> no effect, result still captured.
- Confirm held high 20 cycles in IDLE_A -> only one transition (to GET_OP); confirm and cancel rising together in GET_OP -> IDLE_A.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM for the switch-driven calculator.
// Collects operand A, an operator and operand B (one confirm press each),
// starts the shared ALU with a start/done handshake, waits a bounded time
// and holds the result for display.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   sw, op_sw           operand / operator switches
//   confirm, cancel     debounced level buttons (edge-detected here)
//   alu_a/b/op/start    operands, operator and start pulse to the ALU
//   alu_done/result/err ALU completion strobe, result and error flag
//   result, result_valid, error   held display result and status flags
//   state_dbg           current state encoding for LEDs
module calc_sequencer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned RES_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op_sw,
    input  logic             confirm,
    input  logic             cancel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [RES_W-1:0] alu_result,
    input  logic             alu_err,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             error,
    output logic [2:0]       state_dbg
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE_A = 3'd0,
        GET_OP = 3'd1,
        GET_B  = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        SHOW   = 3'd5
    } state_t;

    state_t             r_state,        w_nxt_state;
    logic [WIDTH-1:0]   r_alu_a,        w_nxt_alu_a;
    logic [WIDTH-1:0]   r_alu_b,        w_nxt_alu_b;
    logic [1:0]         r_alu_op,       w_nxt_alu_op;
    logic               r_alu_start,    w_nxt_alu_start;
    logic [RES_W-1:0]   r_result,       w_nxt_result;
    logic               r_result_valid, w_nxt_result_valid;
    logic               r_error,        w_nxt_error;
    logic [CNT_W-1:0]   r_cnt,          w_nxt_cnt;
    logic               r_confirm_q;
    logic               r_cancel_q;
    logic               w_conf_evt;
    logic               w_cancel_evt;

    // Rising-edge events: one per press regardless of hold length
    assign w_conf_evt   = confirm & ~r_confirm_q;
    assign w_cancel_evt = cancel  & ~r_cancel_q;

    // State and data registers; edge history tracks the buttons even in reset
    // so a button held through reset does not fire on release
    always_ff @(posedge clk) begin
        r_confirm_q <= confirm;
        r_cancel_q  <= cancel;
        if (!reset) begin
            r_state        <= IDLE_A;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_alu_start    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_state        <= w_nxt_state;
            r_alu_a        <= w_nxt_alu_a;
            r_alu_b        <= w_nxt_alu_b;
            r_alu_op       <= w_nxt_alu_op;
            r_alu_start    <= w_nxt_alu_start;
            r_result       <= w_nxt_result;
            r_result_valid <= w_nxt_result_valid;
            r_error        <= w_nxt_error;
            r_cnt          <= w_nxt_cnt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_nxt_state        = r_state;
        w_nxt_alu_a        = r_alu_a;
        w_nxt_alu_b        = r_alu_b;
        w_nxt_alu_op       = r_alu_op;
        w_nxt_alu_start    = 1'b0;
        w_nxt_result       = r_result;
        w_nxt_result_valid = r_result_valid;
        w_nxt_error        = r_error;
        w_nxt_cnt          = r_cnt;

        case (r_state)
            IDLE_A, GET_OP, GET_B: begin
                if (w_cancel_evt) begin
                    w_nxt_state  = IDLE_A;
                    w_nxt_alu_a  = '0;
                    w_nxt_alu_b  = '0;
                    w_nxt_alu_op = '0;
                end else if (w_conf_evt) begin
                    if (r_state == IDLE_A) begin
                        w_nxt_alu_a        = sw;
                        w_nxt_result_valid = 1'b0;
                        w_nxt_error        = 1'b0;
                        w_nxt_state        = GET_OP;
                    end else if (r_state == GET_OP) begin
                        w_nxt_alu_op = op_sw;
                        w_nxt_state  = GET_B;
                    end else begin
                        // alu_start is registered, so it rises together with START
                        w_nxt_alu_b     = sw;
                        w_nxt_alu_start = 1'b1;
                        w_nxt_state     = START;
                    end
                end
            end
            START: begin
                w_nxt_cnt   = '0;
                w_nxt_state = WAIT;
            end
            WAIT: begin
                // Completion wins over a timeout in the same cycle
                if (alu_done) begin
                    w_nxt_result       = alu_result;
                    w_nxt_error        = alu_err;
                    w_nxt_result_valid = ~alu_err;
                    w_nxt_state        = SHOW;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_nxt_error        = 1'b1;
                    w_nxt_result_valid = 1'b0;
                    w_nxt_state        = SHOW;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            SHOW: begin
                if (w_cancel_evt) begin
                    w_nxt_result       = '0;
                    w_nxt_result_valid = 1'b0;
                    w_nxt_error        = 1'b0;
                    w_nxt_state        = IDLE_A;
                end else if (w_conf_evt) begin
                    // Chained calculation: this press supplies the new operand A
                    w_nxt_alu_a        = sw;
                    w_nxt_result_valid = 1'b0;
                    w_nxt_error        = 1'b0;
                    w_nxt_state        = GET_OP;
                end
            end
            default: begin
                w_nxt_state = IDLE_A;
            end
        endcase
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign alu_start    = r_alu_start;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign error        = r_error;
    assign state_dbg    = 3'(r_state);

endmodule
